// File: rtl/rv_test_monitor_pkg.sv
// Shared types and constants for the riscv-tests completion monitor.
package rv_test_pkg;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    RUN     = 3'd1,
    PASS    = 3'd2,
    FAIL    = 3'd3,
    TIMEOUT = 3'd4
  } state_t;

  localparam logic [31:0] ECALL_WORD = 32'h0000_0073;
  localparam logic [31:0] EXIT_CODE  = 32'd93;

  localparam logic [4:0] REG_GP = 5'd3;
  localparam logic [4:0] REG_A0 = 5'd10;
  localparam logic [4:0] REG_A7 = 5'd17;

endpackage

// File: rtl/rv_test_monitor_if.sv
// Snoop bus from the CPU: run enable, issuing instruction and register-file write port.
interface rv_test_monitor_if;
  logic        en;
  logic [31:0] instr;
  logic        RegWr;
  logic [4:0]  rd;
  logic [31:0] new_data;

  modport master (output en, instr, RegWr, rd, new_data);
  modport slave  (input  en, instr, RegWr, rd, new_data);
endinterface

// File: rtl/rv_test_monitor_shadow.sv
// Shadow copies of x3/x10/x17 with same-cycle write bypass for the exit check.
module rv_monitor_shadow
  import rv_test_pkg::*;
(
  input  logic        clock,
  input  logic        reset,
  input  logic        cap_en_i,
  input  logic        wr_i,
  input  logic [4:0]  rd_i,
  input  logic [31:0] wdata_i,
  output logic [31:0] shadow_x3_o,
  output logic [31:0] eff_x10_o,
  output logic [31:0] eff_x17_o
);

  logic [31:0] x3_q, x10_q, x17_q;
  logic [31:0] x3_d, x10_d, x17_d;
  logic        hit3, hit10, hit17;

  assign hit3  = wr_i && (rd_i == REG_GP);
  assign hit10 = wr_i && (rd_i == REG_A0);
  assign hit17 = wr_i && (rd_i == REG_A7);

  always_comb begin
    x3_d  = x3_q;
    x10_d = x10_q;
    x17_d = x17_q;
    if (cap_en_i) begin
      if (hit3)  x3_d  = wdata_i;
      if (hit10) x10_d = wdata_i;
      if (hit17) x17_d = wdata_i;
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      x3_q  <= '0;
      x10_q <= '0;
      x17_q <= '0;
    end else begin
      x3_q  <= x3_d;
      x10_q <= x10_d;
      x17_q <= x17_d;
    end
  end

  assign shadow_x3_o = x3_q;
  assign eff_x10_o   = hit10 ? wdata_i : x10_q;
  assign eff_x17_o   = hit17 ? wdata_i : x17_q;

endmodule

// File: rtl/rv_test_monitor.sv
// riscv-tests completion checker: detects the exit ECALL and reports pass/fail/timeout.
module rv_test_monitor #(
  parameter int          MAX_CYCLES = 840,
  parameter int          CNT_WIDTH  = 16,
  parameter logic [31:0] EXIT_CODE  = rv_test_pkg::EXIT_CODE,
  parameter logic [31:0] ECALL_WORD = rv_test_pkg::ECALL_WORD
) (
  input  logic                 clock,
  input  logic                 reset,
  rv_test_monitor_if.slave     bus,
  output logic                 done,
  output logic                 pass,
  output logic                 fail,
  output logic                 timeout,
  output logic [30:0]          fail_testnum,
  output logic [31:0]          test_num,
  output logic [CNT_WIDTH-1:0] cycle_count
);
  import rv_test_pkg::*;

  state_t               state_q, state_d;
  logic [CNT_WIDTH-1:0] cnt_q, cnt_d;
  logic [30:0]          ftn_q, ftn_d;
  logic [31:0]          eff_x10, eff_x17;
  logic                 active;
  logic                 exit_seen;

  assign active = (state_q == IDLE) || (state_q == RUN);

  rv_monitor_shadow u_shadow (
    .clock       (clock),
    .reset       (reset),
    .cap_en_i    (active),
    .wr_i        (bus.RegWr),
    .rd_i        (bus.rd),
    .wdata_i     (bus.new_data),
    .shadow_x3_o (test_num),
    .eff_x10_o   (eff_x10),
    .eff_x17_o   (eff_x17)
  );

  assign exit_seen = (bus.instr == ECALL_WORD) && (eff_x17 == EXIT_CODE);

  // Every enabled cycle before a terminal state is counted, including the one
  // that leaves IDLE, so the count is "enabled cycles since reset".
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    ftn_d   = ftn_q;
    case (state_q)
      IDLE: begin
        if (bus.en) begin
          state_d = RUN;
          cnt_d   = cnt_q + 1'b1;
        end
      end
      RUN: begin
        if (bus.en) begin
          cnt_d = cnt_q + 1'b1;
          if (exit_seen) begin
            if (eff_x10 == 32'd0) begin
              state_d = PASS;
            end else begin
              state_d = FAIL;
              ftn_d   = eff_x10[31:1];
            end
          end else if (cnt_q == CNT_WIDTH'(MAX_CYCLES - 1)) begin
            state_d = TIMEOUT;
          end
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      ftn_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      ftn_q   <= ftn_d;
    end
  end

  assign pass         = (state_q == PASS);
  assign fail         = (state_q == FAIL);
  assign timeout      = (state_q == TIMEOUT);
  assign done         = pass | fail | timeout;
  assign fail_testnum = ftn_q;
  assign cycle_count  = cnt_q;

endmodule
